// File: rtl/cpu_bus_master.sv
// CPU-side bus initiator: splits one 8/16-bit core access into little-endian byte
// transfers on the req_rdwr/data_ready handshake, with per-byte timeout.
module cpu_bus_master #(
    parameter int unsigned ADDR_WIDTH     = 24,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned BANK_WRAP      = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      start,
    input  logic                      is_write,
    input  logic                      is_word,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [2*DATA_WIDTH-1:0]   wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [2*DATA_WIDTH-1:0]   rdata,
    output logic                      req_rdwr,
    output logic                      which_rdwr,
    output logic [ADDR_WIDTH-1:0]     addr,
    output logic [DATA_WIDTH-1:0]     data_out,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      data_ready
);

    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    // Bits of the address that take part in the +1 for the high byte.
    localparam logic [AW-1:0] INC_MASK = (BANK_WRAP != 0) ? AW'(17'h0FFFF) : '1;
    localparam logic WH_READ  = 1'b0;
    localparam logic WH_WRITE = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_FIN} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;
    logic            r_error, w_error_nxt;
    logic [2*DW-1:0] r_rdata, w_rdata_nxt;
    logic            r_req, w_req_nxt;
    logic            r_which, w_which_nxt;
    logic [AW-1:0]   r_addr, w_addr_nxt;
    logic [DW-1:0]   r_dout, w_dout_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_word, w_word_nxt;
    logic [AW-1:0]   r_base, w_base_nxt;
    logic [DW-1:0]   r_wdata_hi, w_wdata_hi_nxt;

    logic            w_byte_ok;
    logic            w_tmo;
    logic [AW-1:0]   w_addr_inc;

    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign rdata      = r_rdata;
    assign req_rdwr   = r_req;
    assign which_rdwr = r_which;
    assign addr       = r_addr;
    assign data_out   = r_dout;

    always_comb begin
        w_byte_ok  = r_req && data_ready;
        w_tmo      = (TIMEOUT_CYCLES > 0) && r_req && !data_ready && (r_cnt == CNT_LAST);
        w_addr_inc = (r_base & ~INC_MASK) | ((r_base + AW'(1)) & INC_MASK);
    end

    // Next-state and registered-output logic; everything holds while enable is low.
    always_comb begin
        w_state_nxt    = r_state;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_error_nxt    = r_error;
        w_rdata_nxt    = r_rdata;
        w_req_nxt      = r_req;
        w_which_nxt    = r_which;
        w_addr_nxt     = r_addr;
        w_dout_nxt     = r_dout;
        w_cnt_nxt      = r_cnt;
        w_word_nxt     = r_word;
        w_base_nxt     = r_base;
        w_wdata_hi_nxt = r_wdata_hi;

        if (enable) begin
            w_done_nxt  = 1'b0;
            w_error_nxt = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt    = S_LO;
                        w_busy_nxt     = 1'b1;
                        w_req_nxt      = 1'b1;
                        w_which_nxt    = is_write ? WH_WRITE : WH_READ;
                        w_addr_nxt     = req_addr;
                        w_dout_nxt     = wdata[DW-1:0];
                        w_cnt_nxt      = '0;
                        w_word_nxt     = is_word;
                        w_base_nxt     = req_addr;
                        w_wdata_hi_nxt = wdata[2*DW-1:DW];
                    end
                end
                S_LO, S_HI: begin
                    if (r_state == S_HI && !r_req) begin
                        // Mandatory idle cycle between bytes.
                        w_req_nxt = 1'b1;
                    end else if (w_byte_ok) begin
                        w_req_nxt = 1'b0;
                        w_cnt_nxt = '0;
                        if (r_which == WH_READ) begin
                            if (r_state == S_LO)
                                w_rdata_nxt = {DW'(0), data_in};
                            else
                                w_rdata_nxt[2*DW-1:DW] = data_in;
                        end
                        if (r_state == S_LO && r_word) begin
                            w_state_nxt = S_HI;
                            w_addr_nxt  = w_addr_inc;
                            w_dout_nxt  = r_wdata_hi;
                        end else begin
                            w_state_nxt = S_FIN;
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                        end
                    end else if (w_tmo) begin
                        w_state_nxt = S_FIN;
                        w_done_nxt  = 1'b1;
                        w_error_nxt = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_req_nxt   = 1'b0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                S_FIN: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_rdata    <= '0;
            r_req      <= 1'b0;
            r_which    <= WH_READ;
            r_addr     <= '0;
            r_dout     <= '0;
            r_cnt      <= '0;
            r_word     <= 1'b0;
            r_base     <= '0;
            r_wdata_hi <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_rdata    <= w_rdata_nxt;
            r_req      <= w_req_nxt;
            r_which    <= w_which_nxt;
            r_addr     <= w_addr_nxt;
            r_dout     <= w_dout_nxt;
            r_cnt      <= w_cnt_nxt;
            r_word     <= w_word_nxt;
            r_base     <= w_base_nxt;
            r_wdata_hi <= w_wdata_hi_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master; two instances differ only in high-byte address wrap.
module tb_cpu_bus_master;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        start;
    logic        is_write;
    logic        is_word;
    logic [23:0] req_addr;
    logic [15:0] wdata;
    logic [7:0]  data_in;
    logic        data_ready;

    logic        busy, done, error, req_rdwr, which_rdwr;
    logic [15:0] rdata;
    logic [23:0] addr;
    logic [7:0]  data_out;

    logic        busy_b, done_b, error_b, req_rdwr_b, which_rdwr_b;
    logic [15:0] rdata_b;
    logic [23:0] addr_b;
    logic [7:0]  data_out_b;

    int n_checks = 0;
    int n_errors = 0;

    cpu_bus_master #(.ADDR_WIDTH(24), .DATA_WIDTH(8), .TIMEOUT_CYCLES(15), .BANK_WRAP(0)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .is_write(is_write),
        .is_word(is_word), .req_addr(req_addr), .wdata(wdata), .busy(busy), .done(done),
        .error(error), .rdata(rdata), .req_rdwr(req_rdwr), .which_rdwr(which_rdwr),
        .addr(addr), .data_out(data_out), .data_in(data_in), .data_ready(data_ready)
    );

    cpu_bus_master #(.ADDR_WIDTH(24), .DATA_WIDTH(8), .TIMEOUT_CYCLES(15), .BANK_WRAP(1)) u_dut_wrap (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .is_write(is_write),
        .is_word(is_word), .req_addr(req_addr), .wdata(wdata), .busy(busy_b), .done(done_b),
        .error(error_b), .rdata(rdata_b), .req_rdwr(req_rdwr_b), .which_rdwr(which_rdwr_b),
        .addr(addr_b), .data_out(data_out_b), .data_in(data_in), .data_ready(data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic word, input logic [23:0] a, input logic [15:0] d);
        start    = 1'b1;
        is_write = wr;
        is_word  = word;
        req_addr = a;
        wdata    = d;
        step();
        start    = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; enable = 1'b1; start = 1'b0; is_write = 1'b0; is_word = 1'b0;
        req_addr = '0; wdata = '0; data_in = '0; data_ready = 1'b0;
        step(); step();

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_req", 32'(req_rdwr), 32'd0);
        check("rst_which", 32'(which_rdwr), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        step();

        // 8-bit read with two wait states
        issue(1'b0, 1'b0, 24'h000010, 16'h0000);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_req", 32'(req_rdwr), 32'd1);
        check("t1_addr", 32'(addr), 32'h10);
        check("t1_which", 32'(which_rdwr), 32'd0);
        step();
        check("t1_req_hold", 32'(req_rdwr), 32'd1);
        step();
        data_ready = 1'b1; data_in = 8'hA5;
        step();
        data_ready = 1'b0;
        check("t1_done", 32'(done), 32'd1);
        check("t1_error", 32'(error), 32'd0);
        check("t1_busy_fin", 32'(busy), 32'd0);
        check("t1_req_fin", 32'(req_rdwr), 32'd0);
        check("t1_rdata", 32'(rdata), 32'h00A5);
        step();
        check("t1_done_pulse", 32'(done), 32'd0);

        // 16-bit write, zero wait states
        issue(1'b1, 1'b1, 24'h001234, 16'hBEEF);
        check("t2_addr_lo", 32'(addr), 32'h001234);
        check("t2_dout_lo", 32'(data_out), 32'hEF);
        check("t2_which", 32'(which_rdwr), 32'd1);
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        check("t2_gap_req", 32'(req_rdwr), 32'd0);
        check("t2_addr_hi", 32'(addr), 32'h001235);
        check("t2_dout_hi", 32'(data_out), 32'hBE);
        step();
        check("t2_req_hi", 32'(req_rdwr), 32'd1);
        check("t2_no_done", 32'(done), 32'd0);
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        check("t2_done", 32'(done), 32'd1);
        check("t2_which_fin", 32'(which_rdwr), 32'd1);
        step();

        // 16-bit read across a 64K boundary, both wrap modes
        issue(1'b0, 1'b1, 24'h12FFFF, 16'h0000);
        check("t3_addr_lo", 32'(addr), 32'h12FFFF);
        data_ready = 1'b1; data_in = 8'h34;
        step();
        data_ready = 1'b0;
        check("t3_addr_hi_lin", 32'(addr), 32'h130000);
        check("t3_addr_hi_bank", 32'(addr_b), 32'h120000);
        step();
        data_ready = 1'b1; data_in = 8'h12;
        step();
        data_ready = 1'b0;
        check("t3_done", 32'(done), 32'd1);
        check("t3_rdata", 32'(rdata), 32'h1234);
        check("t3_rdata_bank", 32'(rdata_b), 32'h1234);
        step();

        // Linear wrap at top of address space
        issue(1'b0, 1'b1, 24'hFFFFFF, 16'h0000);
        data_ready = 1'b1; data_in = 8'h01;
        step();
        data_ready = 1'b0;
        check("t3_addr_top", 32'(addr), 32'h000000);
        check("t3_addr_top_bank", 32'(addr_b), 32'hFF0000);
        step();
        data_ready = 1'b1; data_in = 8'h02;
        step();
        data_ready = 1'b0;
        step();

        // Timeout on the low byte
        issue(1'b0, 1'b0, 24'h000055, 16'h0000);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (done) begin
                n = i;
                break;
            end
        end
        check("t4_tmo_cycles", 32'(n), 32'd15);
        check("t4_error", 32'(error), 32'd1);
        check("t4_req", 32'(req_rdwr), 32'd0);
        step();
        check("t4_req_after", 32'(req_rdwr), 32'd0);
        check("t4_error_clr", 32'(error), 32'd0);

        // Reset during the high-byte wait
        issue(1'b0, 1'b1, 24'h000200, 16'h0000);
        data_ready = 1'b1; data_in = 8'h11;
        step();
        data_ready = 1'b0;
        step();
        check("t5_hi_req", 32'(req_rdwr), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_req", 32'(req_rdwr), 32'd0);
        check("t5_addr", 32'(addr), 32'd0);
        check("t5_rdata", 32'(rdata), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        step();
        check("t5_no_done", 32'(done), 32'd0);
        issue(1'b1, 1'b0, 24'h000042, 16'h007E);
        check("t5_new_addr", 32'(addr), 32'h42);
        check("t5_new_dout", 32'(data_out), 32'h7E);
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        check("t5_new_done", 32'(done), 32'd1);
        step();

        // Stray data_ready in IDLE, then start held high through a transfer
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        check("t6_stray_busy", 32'(busy), 32'd0);
        check("t6_stray_done", 32'(done), 32'd0);
        start = 1'b1; is_write = 1'b0; is_word = 1'b0; req_addr = 24'h000080;
        step();
        check("t6_busy", 32'(busy), 32'd1);
        req_addr = 24'h000099;
        step();
        check("t6_addr_held", 32'(addr), 32'h80);
        data_ready = 1'b1; data_in = 8'h3C;
        step();
        data_ready = 1'b0;
        check("t6_done", 32'(done), 32'd1);
        check("t6_rdata", 32'(rdata), 32'h003C);
        step();
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_idle_req", 32'(req_rdwr), 32'd0);
        step();
        start = 1'b0;
        check("t6_second_busy", 32'(busy), 32'd1);
        check("t6_second_addr", 32'(addr), 32'h99);
        data_ready = 1'b1; data_in = 8'h00;
        step();
        data_ready = 1'b0;
        check("t6_second_done", 32'(done), 32'd1);
        step();

        // enable low freezes the transfer and ignores data_ready
        issue(1'b0, 1'b0, 24'h000077, 16'h0000);
        enable = 1'b0;
        data_ready = 1'b1; data_in = 8'h5A;
        step(); step();
        check("t7_frozen_req", 32'(req_rdwr), 32'd1);
        check("t7_frozen_done", 32'(done), 32'd0);
        enable = 1'b1;
        step();
        data_ready = 1'b0;
        check("t7_done", 32'(done), 32'd1);
        check("t7_rdata", 32'(rdata), 32'h005A);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
